// File: rtl/axil_cmd_master_if.sv
// AXI-Lite interface bundle (axil_if) used by axil_cmd_master.
// clk_i/arstn_i travel with the bundle for slaves that want them.
interface axil_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic clk_i,
    input logic arstn_i
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_cmd_master.sv
// Command-stream to AXI-Lite initiator, one outstanding transaction at a time.
// Optional macro AXIL_TIMEOUT_EN adds a per-transaction watchdog and idle B/R draining.
module axil_cmd_master #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 'h200000,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic                    rsp_we_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic [1:0]              rsp_resp_o,
    axil_if.master                  m_axil
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA, RSP} state_t;

    state_t                  state;
    logic                    awvalid, wvalid, arvalid, bready, rready;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;
    logic                    we_q;
    logic                    accept, aw_done, w_done, busy, tmo;

    function automatic logic [ADDR_WIDTH-1:0] abs_addr(input logic [ADDR_WIDTH-1:0] off);
        return off + BASE_ADDR;
    endfunction

    assign accept  = cmd_valid_i && cmd_ready_o;
    assign aw_done = !awvalid || m_axil.awready;
    assign w_done  = !wvalid  || m_axil.wready;
    assign busy    = (state == WR) || (state == WR_RESP) || (state == RD) || (state == RD_DATA);

`ifdef AXIL_TIMEOUT_EN
    localparam int   CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic IDLE_READY = 1'b1;
    logic [CNT_W-1:0] tmo_cnt;

    // Counter reads k-1 during the k-th busy cycle; firing at TIMEOUT_CYCLES-2 makes the
    // error response visible TIMEOUT_CYCLES cycles after the accept cycle, matching how
    // the 3-cycle normal latency is counted.
    always_ff @(posedge clk_i) begin
        if (rst_i || state == IDLE) tmo_cnt <= '0;
        else if (busy)              tmo_cnt <= tmo_cnt + 1'b1;
    end
    assign tmo = busy && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 2));
`else
    localparam logic IDLE_READY = 1'b0;
    assign tmo = 1'b0;
`endif

    // Command capture: held stable for the whole transaction.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_q  <= abs_addr(cmd_addr_i);
            wdata_q <= cmd_wdata_i;
            wstrb_q <= cmd_wstrb_i;
            we_q    <= cmd_we_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            arvalid     <= 1'b0;
            bready      <= 1'b0;
            rready      <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_we_o    <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_resp_o  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    bready <= IDLE_READY;
                    rready <= IDLE_READY;
                    if (accept) begin
                        cmd_ready_o <= 1'b0;
                        bready      <= 1'b0;
                        rready      <= 1'b0;
                        if (cmd_we_i) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= RD;
                        end
                    end
                end
                WR: begin
                    // AW and W retire independently; leave only once both have.
                    if (awvalid && m_axil.awready) awvalid <= 1'b0;
                    if (wvalid && m_axil.wready)   wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axil.bvalid) begin
                        bready      <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_we_o    <= 1'b1;
                        rsp_resp_o  <= m_axil.bresp;
                        rsp_rdata_o <= '0;
                        state       <= RSP;
                    end
                end
                RD: begin
                    if (m_axil.arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axil.rvalid) begin
                        rready      <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_we_o    <= 1'b0;
                        rsp_resp_o  <= m_axil.rresp;
                        rsp_rdata_o <= m_axil.rdata;
                        state       <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        bready      <= IDLE_READY;
                        rready      <= IDLE_READY;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Watchdog expiry wins over a handshake landing in the same cycle.
            if (tmo) begin
                awvalid     <= 1'b0;
                wvalid      <= 1'b0;
                arvalid     <= 1'b0;
                bready      <= 1'b0;
                rready      <= 1'b0;
                rsp_valid_o <= 1'b1;
                rsp_we_o    <= we_q;
                rsp_resp_o  <= 2'b11;
                rsp_rdata_o <= '0;
                state       <= RSP;
            end
        end
    end

    assign m_axil.awaddr  = addr_q;
    assign m_axil.awprot  = 3'b000;
    assign m_axil.awvalid = awvalid;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = wstrb_q;
    assign m_axil.wvalid  = wvalid;
    assign m_axil.bready  = bready;
    assign m_axil.araddr  = addr_q;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.arvalid = arvalid;
    assign m_axil.rready  = rready;
endmodule
